// File: rtl/dcache_ctrl_nway.sv
// dcache_ctrl_nway: 1- or 2-way write-back, write-allocate data cache with LRU.
// Define DCACHE_STATS_EN to add saturating hit/miss/write-back counters.
module dcache_ctrl_nway #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int LINE_BITS = 256,
   parameter int SETS      = 16,
   parameter int WAYS      = 2
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [ADDR_W-1:0]    cpu_addr_i,
   input  logic [DATA_W-1:0]    cpu_data_i,
   input  logic                 cpu_MemRead_i,
   input  logic                 cpu_MemWrite_i,
   output logic [DATA_W-1:0]    cpu_data_o,
   output logic                 cpu_stall_o,
   input  logic [LINE_BITS-1:0] mem_data_i,
   input  logic                 mem_ack_i,
   output logic [LINE_BITS-1:0] mem_data_o,
   output logic [ADDR_W-1:0]    mem_addr_o,
   output logic                 mem_enable_o,
   output logic                 mem_write_o
`ifdef DCACHE_STATS_EN
   ,
   output logic [31:0]          stat_hit_o,
   output logic [31:0]          stat_miss_o,
   output logic [31:0]          stat_wb_o
`endif
);

   localparam int OFF_W = $clog2(LINE_BITS / 8);
   localparam int IDX_W = $clog2(SETS);
   localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
   localparam int WRD_W = OFF_W - 2;
   localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

   typedef enum logic [1:0] {IDLE, WB, REFILL, DONE} state_t;

   state_t state_q, state_d;

   logic [LINE_BITS-1:0] lines_q [WAYS][SETS];
   logic [TAG_W-1:0]     tags_q  [WAYS][SETS];
   logic [SETS-1:0]      valid_q [WAYS];
   logic [SETS-1:0]      dirty_q [WAYS];
   logic [SETS-1:0]      lru_q;

   logic [WAY_W-1:0]  victim_q;
   logic [TAG_W-1:0]  rtag_q;
   logic [IDX_W-1:0]  ridx_q;
   logic [DATA_W-1:0] data_q;

   logic [TAG_W-1:0]  tag;
   logic [IDX_W-1:0]  idx;
   logic [WRD_W-1:0]  word;
   logic              req;
   logic              wr;
   logic              hit;
   logic [WAY_W-1:0]  hit_way;
   logic [DATA_W-1:0] hit_word;
   logic [WAY_W-1:0]  victim;
   logic              found;
   logic              victim_dirty;
   logic              hit_acc;
   logic              miss;
   logic              refill_ack;
   logic              unused_bits;

   assign tag  = cpu_addr_i[ADDR_W-1 -: TAG_W];
   assign idx  = cpu_addr_i[OFF_W +: IDX_W];
   assign word = cpu_addr_i[2 +: WRD_W];
   assign req  = cpu_MemRead_i | cpu_MemWrite_i;
   assign wr   = cpu_MemWrite_i;

   assign unused_bits = ^cpu_addr_i[1:0];

   always_comb begin
      hit     = 1'b0;
      hit_way = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (valid_q[w][idx] && tags_q[w][idx] == tag) begin
            hit     = 1'b1;
            hit_way = WAY_W'(w);
         end
      end
   end

   assign hit_word = lines_q[hit_way][idx][word*DATA_W +: DATA_W];

   // An empty way always wins over evicting the LRU one.
   always_comb begin
      victim = (WAYS > 1) ? WAY_W'(lru_q[idx]) : '0;
      found  = 1'b0;
      for (int w = 0; w < WAYS; w++) begin
         if (!found && !valid_q[w][idx]) begin
            victim = WAY_W'(w);
            found  = 1'b1;
         end
      end
   end

   assign victim_dirty = valid_q[victim][idx] & dirty_q[victim][idx];
   assign hit_acc      = (state_q == IDLE) & req & hit;
   assign miss         = (state_q == IDLE) & req & ~hit;
   assign refill_ack   = (state_q == REFILL) & mem_ack_i;

   assign cpu_data_o = (hit_acc && !wr) ? hit_word : data_q;

   always_comb begin
      state_d      = state_q;
      cpu_stall_o  = 1'b0;
      mem_enable_o = 1'b0;
      mem_write_o  = 1'b0;
      mem_addr_o   = '0;
      mem_data_o   = '0;
      unique case (state_q)
         IDLE: begin
            if (miss) begin
               cpu_stall_o = 1'b1;
               state_d     = victim_dirty ? WB : REFILL;
            end
         end
         WB: begin
            cpu_stall_o  = 1'b1;
            mem_enable_o = 1'b1;
            mem_write_o  = 1'b1;
            mem_addr_o   = {tags_q[victim_q][ridx_q], ridx_q, {OFF_W{1'b0}}};
            mem_data_o   = lines_q[victim_q][ridx_q];
            if (mem_ack_i) state_d = REFILL;
         end
         REFILL: begin
            cpu_stall_o  = 1'b1;
            mem_enable_o = 1'b1;
            mem_addr_o   = {rtag_q, ridx_q, {OFF_W{1'b0}}};
            if (mem_ack_i) state_d = DONE;
         end
         DONE: begin
            cpu_stall_o = 1'b1;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         lru_q    <= '0;
         data_q   <= '0;
         victim_q <= '0;
         rtag_q   <= '0;
         ridx_q   <= '0;
         for (int w = 0; w < WAYS; w++) begin
            valid_q[w] <= '0;
            dirty_q[w] <= '0;
         end
      end else begin
         state_q <= state_d;
         if (miss) begin
            victim_q <= victim;
            rtag_q   <= tag;
            ridx_q   <= idx;
         end
         if (hit_acc) begin
            if (WAYS > 1) lru_q[idx] <= ~hit_way[0];
            if (wr) dirty_q[hit_way][idx] <= 1'b1;
            else data_q <= hit_word;
         end
         if (refill_ack) begin
            valid_q[victim_q][ridx_q] <= 1'b1;
            dirty_q[victim_q][ridx_q] <= 1'b0;
         end
      end
   end

   // Line and tag storage carries no reset; valid bits gate its use.
   always_ff @(posedge clk_i) begin
      if (refill_ack) begin
         lines_q[victim_q][ridx_q] <= mem_data_i;
         tags_q[victim_q][ridx_q]  <= rtag_q;
      end else if (hit_acc && wr) begin
         lines_q[hit_way][idx][word*DATA_W +: DATA_W] <= cpu_data_i;
      end
   end

`ifdef DCACHE_STATS_EN
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stat_hit_o  <= '0;
         stat_miss_o <= '0;
         stat_wb_o   <= '0;
      end else begin
         if (hit_acc && stat_hit_o != '1) stat_hit_o <= stat_hit_o + 32'd1;
         if (miss && stat_miss_o != '1) stat_miss_o <= stat_miss_o + 32'd1;
         if (state_q == WB && mem_ack_i && stat_wb_o != '1)
            stat_wb_o <= stat_wb_o + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_dcache_ctrl_nway.sv
// tb_dcache_ctrl_nway: directed and random accesses against a recency-list
// cache model with a line-addressed backing memory.
module tb_dcache_ctrl_nway;

   localparam int WAYS = 2;

   logic         clk = 1'b0;
   logic         rst;
   logic [31:0]  cpu_addr;
   logic [31:0]  cpu_wdata;
   logic         mem_read;
   logic         mem_wr;
   logic [31:0]  cpu_rdata;
   logic         stall;
   logic [255:0] mem_rdata;
   logic         ack;
   logic [255:0] mem_wdata;
   logic [31:0]  mem_addr;
   logic         mem_en;
   logic         mem_we;
`ifdef DCACHE_STATS_EN
   logic [31:0]  st_hit;
   logic [31:0]  st_miss;
   logic [31:0]  st_wb;
`endif

   always #5 clk = ~clk;

   dcache_ctrl_nway dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .cpu_addr_i     (cpu_addr),
      .cpu_data_i     (cpu_wdata),
      .cpu_MemRead_i  (mem_read),
      .cpu_MemWrite_i (mem_wr),
      .cpu_data_o     (cpu_rdata),
      .cpu_stall_o    (stall),
      .mem_data_i     (mem_rdata),
      .mem_ack_i      (ack),
      .mem_data_o     (mem_wdata),
      .mem_addr_o     (mem_addr),
      .mem_enable_o   (mem_en),
      .mem_write_o    (mem_we)
`ifdef DCACHE_STATS_EN
      ,
      .stat_hit_o     (st_hit),
      .stat_miss_o    (st_miss),
      .stat_wb_o      (st_wb)
`endif
   );

   typedef struct {
      logic [22:0]  tag;
      bit           dirty;
      logic [255:0] data;
   } ent_t;

   // Each set is a recency list: front = most recent, back = eviction candidate.
   ent_t         cset [16][$];
   logic [255:0] memm [logic [31:0]];

   int          total = 0;
   int          bad = 0;
   int          fixed_lat = 0;
   logic [31:0] last_rd;
   int          n_hit, n_miss, n_wb;

   task automatic chk(input string tag, input logic [255:0] obs,
                      input logic [255:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [255:0] fetch(input logic [31:0] la);
      logic [255:0] l;
      if (!memm.exists(la)) begin
         for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
         memm[la] = l;
      end
      return memm[la];
   endfunction

   function automatic int find(input int ix, input logic [22:0] t);
      for (int i = 0; i < cset[ix].size(); i++)
         if (cset[ix][i].tag == t) return i;
      return -1;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 16; i++) cset[i].delete();
      n_hit = 0;
      n_miss = 0;
      n_wb = 0;
      last_rd = '0;
   endtask

   // Acts as memory for one transfer: checks the request each cycle, acks after lat.
   task automatic serve(input bit we, input logic [31:0] la,
                        input logic [255:0] wdata);
      int lat;
      lat = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 6));
      for (int k = 0; k < lat; k++) begin
         @(negedge clk);
         #1;
         chk("mem_en", mem_en, 1'b1);
         chk("mem_we", mem_we, we);
         chk("mem_addr", mem_addr, la);
         if (we) chk("wb_data", mem_wdata, wdata);
         if (k == lat - 1) begin
            mem_rdata = we ? '0 : fetch(la);
            ack = 1'b1;
         end
      end
      @(negedge clk);
      ack = 1'b0;
   endtask

   task automatic access(input bit rd, input bit wr, input logic [31:0] a,
                         input logic [31:0] d);
      logic [22:0] t;
      logic [3:0]  ixb;
      int          ix, w, pos;
      ent_t        e;
      t = a[31:9];
      ixb = a[8:5];
      ix = int'(ixb);
      w = int'(a[4:2]);
      @(negedge clk);
      cpu_addr = a;
      cpu_wdata = d;
      mem_read = rd;
      mem_wr = wr;
      #1;
      pos = find(ix, t);
      if (pos < 0) begin
         chk("miss_stall", stall, 1'b1);
         n_miss++;
         if (cset[ix].size() == WAYS) begin
            e = cset[ix].pop_back();
            if (e.dirty) begin
               serve(1'b1, {e.tag, ixb, 5'b0}, e.data);
               memm[{e.tag, ixb, 5'b0}] = e.data;
               n_wb++;
            end
         end
         serve(1'b0, {t, ixb, 5'b0}, '0);
         e.tag = t;
         e.dirty = 1'b0;
         e.data = fetch({t, ixb, 5'b0});
         cset[ix].push_front(e);
         #1;
         chk("done_stall", stall, 1'b1);
         chk("done_en", mem_en, 1'b0);
         @(negedge clk);
         #1;
         pos = 0;
      end
      e = cset[ix][pos];
      cset[ix].delete(pos);
      chk("hit_stall", stall, 1'b0);
      n_hit++;
      if (wr) begin
         e.data[w*32 +: 32] = d;
         e.dirty = 1'b1;
      end else begin
         chk("rd_data", cpu_rdata, e.data[w*32 +: 32]);
         last_rd = e.data[w*32 +: 32];
      end
      cset[ix].push_front(e);
   endtask

   task automatic idle_cycle();
      @(negedge clk);
      mem_read = 1'b0;
      mem_wr = 1'b0;
      #1;
      chk("idle_stall", stall, 1'b0);
      chk("idle_hold", cpu_rdata, last_rd);
      chk("idle_en", mem_en, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      mem_read = 1'b0;
      mem_wr = 1'b0;
      ack = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_clear();
      #1;
      chk("rst_stall", stall, 1'b0);
      chk("rst_en", mem_en, 1'b0);
      chk("rst_we", mem_we, 1'b0);
      chk("rst_data", cpu_rdata, 32'h0);
   endtask

`ifdef DCACHE_STATS_EN
   task automatic chk_stats();
      chk("stat_hit", st_hit, n_hit);
      chk("stat_miss", st_miss, n_miss);
      chk("stat_wb", st_wb, n_wb);
   endtask
`endif

   initial begin
      logic [255:0] l40;
      logic [31:0]  a;
      int           op;
      rst = 1'b1;
      cpu_addr = '0;
      cpu_wdata = '0;
      mem_read = 1'b0;
      mem_wr = 1'b0;
      mem_rdata = '0;
      ack = 1'b0;
      model_clear();

      do_reset();

      l40 = fetch(32'h40);
      l40[63:32] = 32'hDEADBEEF;
      memm[32'h40] = l40;
      fixed_lat = 10;
      access(1'b1, 1'b0, 32'h40, 32'h0);
      fixed_lat = 0;
      access(1'b1, 1'b0, 32'h44, 32'h0);
      chk("t1_word1", cpu_rdata, 32'hDEADBEEF);
      idle_cycle();

      access(1'b0, 1'b1, 32'h40, 32'h12345678);
      access(1'b1, 1'b0, 32'h40, 32'h0);
      chk("t2_store", cpu_rdata, 32'h12345678);

      access(1'b1, 1'b1, 32'h48, 32'hCAFEF00D);
      access(1'b1, 1'b0, 32'h48, 32'h0);
      chk("t5_both", cpu_rdata, 32'hCAFEF00D);

      access(1'b1, 1'b0, 32'h040, 32'h0);
      access(1'b0, 1'b1, 32'h240, 32'hA5A5_5A5A);
      access(1'b1, 1'b0, 32'h440, 32'h0);
      access(1'b1, 1'b0, 32'h240, 32'h0);
      chk("t3_240", cpu_rdata, 32'hA5A5_5A5A);
      access(1'b1, 1'b0, 32'h044, 32'h0);
      chk("t3_wb_back", cpu_rdata, 32'hDEADBEEF);
      idle_cycle();
`ifdef DCACHE_STATS_EN
      chk_stats();
`endif

      do_reset();
      @(negedge clk);
      cpu_addr = 32'h40;
      mem_read = 1'b1;
      #1;
      chk("t4_stall", stall, 1'b1);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         #1;
         chk("t4_en", mem_en, 1'b1);
         chk("t4_addr", mem_addr, 32'h40);
      end
      rst = 1'b1;
      mem_read = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      model_clear();
      #1;
      chk("t4_rst_en", mem_en, 1'b0);
      chk("t4_rst_stall", stall, 1'b0);
      mem_rdata = '1;
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      #1;
      chk("t4_ack_en", mem_en, 1'b0);
      chk("t4_ack_stall", stall, 1'b0);
      access(1'b1, 1'b0, 32'h40, 32'h0);

      for (int n = 0; n < 400; n++) begin
         a = ($urandom_range(0, 3) << 9) | ($urandom_range(0, 3) << 5)
           | ($urandom_range(0, 7) << 2);
         op = int'($urandom_range(0, 9));
         if (op < 5) access(1'b1, 1'b0, a, 32'h0);
         else if (op < 8) access(1'b0, 1'b1, a, $urandom);
         else if (op < 9) access(1'b1, 1'b1, a, $urandom);
         else idle_cycle();
      end
      idle_cycle();
`ifdef DCACHE_STATS_EN
      chk_stats();
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
